// File: rtl/ab_feed_ctrl_if.sv
// Memory read port plus the two PE-chain FIFO write ports driven by ab_feed_ctrl.
// master = the sequencer, slave = memory/FIFO side.
interface ab_feed_ctrl_if #(
  parameter int D_WIDTH    = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [D_WIDTH-1:0]    mem_rsp_data;
  logic                  fifo_a_wr_en;
  logic [D_WIDTH-1:0]    fifo_a_wdata;
  logic                  fifo_a_almost_full;
  logic                  fifo_b_wr_en;
  logic [D_WIDTH-1:0]    fifo_b_wdata;
  logic                  fifo_b_almost_full;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output fifo_a_wr_en, fifo_a_wdata,
    input  fifo_a_almost_full,
    output fifo_b_wr_en, fifo_b_wdata,
    input  fifo_b_almost_full
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  fifo_a_wr_en, fifo_a_wdata,
    output fifo_a_almost_full,
    input  fifo_b_wr_en, fifo_b_wdata,
    output fifo_b_almost_full
  );
endinterface

// File: rtl/ab_feed_ctrl.sv
// Fetches A column-blocks and B row-blocks for k_len steps from one shared read port
// and steers the in-order responses into the A/B FIFOs using a 1-bit tag queue.
module ab_feed_ctrl #(
  parameter int D_WIDTH     = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int A_NUM_WIDTH = 4,
  parameter int B_NUM_WIDTH = 4,
  parameter int K_WIDTH     = 16,
  parameter int MAX_OUT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  ab_feed_ctrl_if.master        bus
);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_DRAIN, S_DONE} state_t;

  state_t                 state_reg;
  logic [K_WIDTH-1:0]     k_len_reg;
  logic [K_WIDTH-1:0]     step_reg;
  logic [ADDR_WIDTH-1:0]  a_ptr_reg;
  logic [ADDR_WIDTH-1:0]  b_ptr_reg;
  logic [A_NUM_WIDTH-1:0] a_cnt_reg;
  logic [B_NUM_WIDTH-1:0] b_cnt_reg;
  logic [MAX_OUT-1:0]     tag_reg;
  logic [PTR_W-1:0]       tag_wr_reg;
  logic [PTR_W-1:0]       tag_rd_reg;
  logic [CNT_W-1:0]       out_reg;
  logic [CNT_W-1:0]       out_next;

  logic                   in_load;
  logic                   target_af;
  logic                   accept;
  logic                   rsp_hit;
  logic                   rsp_tag;
  logic                   a_last;
  logic                   b_last;
  logic                   last_step;
  logic [D_WIDTH-1:0]     rsp_data;

  assign in_load   = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);
  assign target_af = (state_reg == S_LOAD_B) ? bus.fifo_b_almost_full : bus.fifo_a_almost_full;

  // Valid only changes on state, outstanding count or almost_full; while stalled the
  // count can only drop, so valid/addr hold until accepted unless almost_full rises.
  assign bus.mem_req_valid = in_load && (out_reg < CNT_W'(MAX_OUT)) && !target_af;
  assign bus.mem_req_addr  = (state_reg == S_LOAD_B) ? b_ptr_reg : a_ptr_reg;

  assign accept    = bus.mem_req_valid && bus.mem_req_ready;
  assign rsp_hit   = bus.mem_rsp_valid && (out_reg != '0);
  assign rsp_tag   = tag_reg[tag_rd_reg];
  assign rsp_data  = bus.mem_rsp_data;
  assign a_last    = &a_cnt_reg;
  assign b_last    = &b_cnt_reg;
  assign last_step = (step_reg == k_len_reg - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin : ctrl_fsm
    if (!rst_n) begin
      state_reg <= S_IDLE;
      k_len_reg <= '0;
      step_reg  <= '0;
      a_ptr_reg <= '0;
      b_ptr_reg <= '0;
      a_cnt_reg <= '0;
      b_cnt_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            k_len_reg <= k_len;
            a_ptr_reg <= a_base;
            b_ptr_reg <= b_base;
            step_reg  <= '0;
            a_cnt_reg <= '0;
            b_cnt_reg <= '0;
            busy      <= 1'b1;
            err       <= 1'b0;
            state_reg <= (k_len == '0) ? S_DONE : S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (accept) begin
            a_ptr_reg <= a_ptr_reg + 1'b1;
            a_cnt_reg <= a_cnt_reg + 1'b1;
            if (a_last) state_reg <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (accept) begin
            b_ptr_reg <= b_ptr_reg + 1'b1;
            b_cnt_reg <= b_cnt_reg + 1'b1;
            if (b_last) begin
              if (last_step) begin
                state_reg <= S_DRAIN;
              end else begin
                step_reg  <= step_reg + 1'b1;
                state_reg <= S_LOAD_A;
              end
            end
          end
        end
        S_DRAIN: begin
          if (out_reg == '0) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          // Arriving from DRAIN the pulse is already out; from k_len==0 it fires here.
          done      <= ~done;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
      if (bus.mem_rsp_valid && (out_reg == '0)) err <= 1'b1;
    end
  end

  always_comb begin
    out_next = out_reg;
    if (accept && !rsp_hit)      out_next = out_reg + 1'b1;
    else if (!accept && rsp_hit) out_next = out_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin : tag_ptrs
    if (!rst_n) begin
      tag_wr_reg <= '0;
      tag_rd_reg <= '0;
      out_reg    <= '0;
    end else begin
      if (accept)  tag_wr_reg <= tag_wr_reg + 1'b1;
      if (rsp_hit) tag_rd_reg <= tag_rd_reg + 1'b1;
      out_reg <= out_next;
    end
  end

  for (genvar gi = 0; gi < MAX_OUT; gi++) begin : gen_tag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_reg[gi] <= 1'b0;
      end else if (accept && (tag_wr_reg == PTR_W'(gi))) begin
        tag_reg[gi] <= (state_reg == S_LOAD_B);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : rsp_steer
    if (!rst_n) begin
      bus.fifo_a_wr_en <= 1'b0;
      bus.fifo_a_wdata <= '0;
      bus.fifo_b_wr_en <= 1'b0;
      bus.fifo_b_wdata <= '0;
    end else begin
      bus.fifo_a_wr_en <= rsp_hit && !rsp_tag;
      bus.fifo_b_wr_en <= rsp_hit && rsp_tag;
      if (rsp_hit && !rsp_tag) bus.fifo_a_wdata <= rsp_data;
      if (rsp_hit && rsp_tag)  bus.fifo_b_wdata <= rsp_data;
    end
  end
endmodule

// File: tb/tb_ab_feed_ctrl.sv
// Self-checking bench for ab_feed_ctrl with S_i=S_j=4: memory model with configurable
// latency, expected address/data queues built from the job parameters.
module tb_ab_feed_ctrl;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int KW = 16;
  localparam int MO = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic [AW-1:0] a_base;
  logic [AW-1:0] b_base;
  logic          busy;
  logic          done;
  logic          err;

  ab_feed_ctrl_if #(.D_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ab_feed_ctrl #(
    .D_WIDTH(DW), .ADDR_WIDTH(AW), .A_NUM_WIDTH(2), .B_NUM_WIDTH(2),
    .K_WIDTH(KW), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_base(a_base), .b_base(b_base), .busy(busy), .done(done), .err(err),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 3;
  logic        ready_rand = 1'b0;
  logic        af_a = 1'b0;
  logic        af_b = 1'b0;
  logic        spur_req = 1'b0;
  int          acc_cnt  = 0;
  int          done_cnt = 0;
  int          out_cnt  = 0;
  int          first_acc = -1;
  int          last_acc  = -1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  rsp_t        pend[$];

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Memory model + output monitor: drive inputs on negedge, sample 1 time unit later.
  initial begin : responder
    forever begin
      @(negedge clk);
      cyc++;
      bus.mem_req_ready      = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.fifo_a_almost_full = af_a;
      bus.fifo_b_almost_full = af_b;
      if (spur_req) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        spur_req = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        rsp_t r;
        r = pend.pop_front();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_word(r.addr);
        if (out_cnt > 0) out_cnt--;
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
      end
      #1;
      if (rst_n) begin
        if (bus.fifo_a_wr_en) begin
          logic [63:0] e;
          n_checks++;
          if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL fifo_a_extra: got write %h, required no write", bus.fifo_a_wdata);
          end else begin
            e = exp_a.pop_front();
            if (bus.fifo_a_wdata !== e) begin
              n_fail++;
              $display("FAIL fifo_a_data: got %h required %h", bus.fifo_a_wdata, e);
            end else $display("fifo_a write %h", bus.fifo_a_wdata);
          end
        end
        if (bus.fifo_b_wr_en) begin
          logic [63:0] e;
          n_checks++;
          if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL fifo_b_extra: got write %h, required no write", bus.fifo_b_wdata);
          end else begin
            e = exp_b.pop_front();
            if (bus.fifo_b_wdata !== e) begin
              n_fail++;
              $display("FAIL fifo_b_data: got %h required %h", bus.fifo_b_wdata, e);
            end else $display("fifo_b write %h", bus.fifo_b_wdata);
          end
        end
        if (done === 1'b1) begin
          done_cnt++;
          n_checks++;
          if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_with_done: got busy=%b required 0", busy);
          end
        end
        if (prev_stall && !af_a && !af_b) begin
          n_checks++;
          if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_addr) begin
            n_fail++;
            $display("FAIL stall_stable: got valid=%b addr=%h required valid=1 addr=%h",
                     bus.mem_req_valid, bus.mem_req_addr, prev_addr);
          end
        end
        if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
          logic [31:0] ea;
          acc_cnt++;
          out_cnt++;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          n_checks++;
          if (out_cnt > MO) begin
            n_fail++;
            $display("FAIL outstanding: got %0d required <= %0d", out_cnt, MO);
          end
          n_checks++;
          if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL req_extra: got addr %h, required no request", bus.mem_req_addr);
          end else begin
            ea = exp_addr.pop_front();
            if (bus.mem_req_addr !== ea) begin
              n_fail++;
              $display("FAIL req_addr: got %h required %h", bus.mem_req_addr, ea);
            end else $display("request addr %h", bus.mem_req_addr);
          end
          pend.push_back('{cyc + lat, bus.mem_req_addr});
        end
        prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
        prev_addr  = bus.mem_req_addr;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic launch(input int k, input logic [31:0] a, input logic [31:0] b);
    for (int s = 0; s < k; s++) begin
      for (int i = 0; i < 4; i++) begin
        exp_addr.push_back(a + 32'(s * 4 + i));
        exp_a.push_back(mem_word(a + 32'(s * 4 + i)));
      end
      for (int j = 0; j < 4; j++) begin
        exp_addr.push_back(b + 32'(s * 4 + j));
        exp_b.push_back(mem_word(b + 32'(s * 4 + j)));
      end
    end
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); a_base = a; b_base = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    #2;
    n_checks++;
    if (done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL %s_done: got %0d done pulses required 1", name, done_cnt - d0);
    end
    n_checks++;
    if (exp_addr.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0) begin
      n_fail++;
      $display("FAIL %s_lost: got pending req=%0d a=%0d b=%0d required 0/0/0",
               name, exp_addr.size(), exp_a.size(), exp_b.size());
    end
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: got err=%b busy=%b required 0/0", name, err, busy);
    end
    $display("%s job complete", name);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if ({bus.mem_req_valid, bus.fifo_a_wr_en, bus.fifo_b_wr_en, busy, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {bus.mem_req_valid, bus.fifo_a_wr_en, bus.fifo_b_wr_en, busy, done, err});
    end
    n_checks++;
    if (bus.mem_req_addr !== 32'h0 || bus.fifo_a_wdata !== 64'h0 || bus.fifo_b_wdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h a=%h b=%h required zeros",
               bus.mem_req_addr, bus.fifo_a_wdata, bus.fifo_b_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (bus.mem_req_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b required 0/0", bus.mem_req_valid, busy);
    end
    $display("reset checked");
  endtask

  task automatic test_nominal;
    lat = 3; ready_rand = 1'b0;
    first_acc = -1;
    launch(2, 32'h100, 32'h200);
    wait_done("nominal", 300);
    n_checks++;
    if (last_acc - first_acc != 15) begin
      n_fail++;
      $display("FAIL nominal_no_bubble: got span %0d cycles required 15", last_acc - first_acc);
    end
  endtask

  task automatic test_backpressure;
    lat = 10; ready_rand = 1'b1;
    launch(3, 32'h4000, 32'h8000);
    wait_done("backpressure", 3000);
    ready_rand = 1'b0; lat = 3;
  endtask

  task automatic test_almost_full;
    int acc0;
    acc0 = acc_cnt;
    af_b = 1'b1;
    launch(1, 32'h500, 32'h600);
    repeat (30) @(negedge clk);
    #2;
    n_checks++;
    if (acc_cnt - acc0 != 4 || bus.mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL af_hold: got %0d requests valid=%b required 4 and valid=0",
               acc_cnt - acc0, bus.mem_req_valid);
    end
    n_checks++;
    if (exp_a.size() != 0 || exp_b.size() != 4) begin
      n_fail++;
      $display("FAIL af_fifo: got pending a=%0d b=%0d required 0/4", exp_a.size(), exp_b.size());
    end
    af_b = 1'b0;
    wait_done("almost_full", 300);
  endtask

  task automatic test_k_zero;
    int acc0;
    acc0 = acc_cnt;
    @(negedge clk);
    start = 1'b1; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    #2;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL kzero_c1: got done=%b busy=%b required 0/1", done, busy);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kzero_c2: got done=%b busy=%b required 1/0", done, busy);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (done !== 1'b0 || acc_cnt != acc0) begin
      n_fail++;
      $display("FAIL kzero_after: got done=%b requests=%0d required 0/0", done, acc_cnt - acc0);
    end
    $display("k_len=0 job complete");
  endtask

  task automatic test_start_busy;
    launch(1, 32'h300, 32'h400);
    repeat (3) @(negedge clk);
    start = 1'b1; k_len = 16'd5; a_base = 32'h999; b_base = 32'hAAA;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_busy", 300);
  endtask

  task automatic test_wrap;
    launch(1, 32'hFFFF_FFFE, 32'h700);
    wait_done("wrap", 300);
  endtask

  task automatic test_spurious;
    @(negedge clk);
    spur_req = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_set: got err=%b required 1", err);
    end
    repeat (5) @(negedge clk);
    #2;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_sticky: got err=%b required 1", err);
    end
    @(negedge clk);
    start = 1'b1; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    #2;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_clear: got err=%b required 0", err);
    end
    repeat (3) @(negedge clk);
    $display("spurious response checked");
  endtask

  task automatic test_reset_mid;
    int acc0;
    int n;
    lat = 8;
    acc0 = acc_cnt;
    launch(2, 32'h100, 32'h200);
    n = 0;
    while (acc_cnt - acc0 < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (acc_cnt - acc0 < 6) begin
      n_fail++;
      $display("FAIL mid_reach_b: got %0d requests required 6", acc_cnt - acc0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    exp_addr.delete(); exp_a.delete(); exp_b.delete();
    out_cnt = 0;
    #1;
    n_checks++;
    if ({bus.mem_req_valid, bus.fifo_a_wr_en, bus.fifo_b_wr_en, busy, done, err} !== 6'b0 ||
        bus.mem_req_addr !== 32'h0 || bus.fifo_a_wdata !== 64'h0 || bus.fifo_b_wdata !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got ctrl=%b addr=%h a=%h b=%h required all zero",
               {bus.mem_req_valid, bus.fifo_a_wr_en, bus.fifo_b_wr_en, busy, done, err},
               bus.mem_req_addr, bus.fifo_a_wdata, bus.fifo_b_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_late_rsp: got err=%b busy=%b valid=%b required 1/0/0",
               err, busy, bus.mem_req_valid);
    end
    $display("mid-job reset checked");
  endtask

  initial begin : main
    rst_n = 1'b0; start = 1'b0; k_len = '0; a_base = '0; b_base = '0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    bus.fifo_a_almost_full = 1'b0; bus.fifo_b_almost_full = 1'b0;
    test_reset;
    test_nominal;
    test_backpressure;
    test_almost_full;
    test_k_zero;
    test_start_busy;
    test_wrap;
    test_spurious;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
